// File: rtl/reg_writeback_arbiter_pkg.sv
// rtl/reg_writeback_arbiter_pkg.sv - shared widths and queue entry type for the register write-back arbiter
// Purpose: common localparams and the load-queue entry struct.
// Ports: none (package).
package reg_writeback_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int WAIT_W    = 8;

  // One queued load result; kill marks an entry superseded by a newer ALU write.
  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
    logic                 kill;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// rtl/reg_writeback_arbiter_if.sv - interface bundling the write-back arbiter streams and register-file port
// Purpose: groups ALU stream, load stream, hazard query and register-file write port.
// Modports:
//   master - arbiter view: consumes ALU/load/query inputs, drives stall, ready, hit, write port, pending
//   slave  - environment view: drives ALU/load/query inputs, observes the rest
// Parameter DEPTH sizes the pending count and must match the arbiter's DEPTH.
interface reg_writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  import reg_writeback_arbiter_pkg::*;

  logic                  alu_valid;
  logic [REG_IDX_W-1:0]  alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_stall;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_IDX_W-1:0]  mem_reg;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_IDX_W-1:0]  query_reg;
  logic                  query_hit;
  logic                  regWrite;
  logic [REG_IDX_W-1:0]  writeReg;
  logic [DATA_W-1:0]     writeData;
  logic [$clog2(DEPTH):0] pending;

  modport master (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
    output alu_stall, mem_ready, query_hit, regWrite, writeReg, writeData, pending
  );

  modport slave (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, query_reg,
    input  alu_stall, mem_ready, query_hit, regWrite, writeReg, writeData, pending
  );

endinterface

// File: rtl/reg_writeback_arbiter_wb_load_queue.sv
// rtl/reg_writeback_arbiter_wb_load_queue.sv - circular load-result queue with kill broadcast and match lookup
// Purpose: DEPTH-entry FIFO of load results (DEPTH a power of two).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_reg/data enqueue at tail
//   pop                 dequeue head (caller guarantees !empty)
//   kill_en, kill_reg   mark every live entry (and a same-cycle push) targeting kill_reg as killed
//   query_reg/query_hit live, non-killed entry targeting query_reg exists
//   head                head entry, count/full/empty occupancy
module wb_load_queue
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [REG_IDX_W-1:0]      push_reg,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [REG_IDX_W-1:0]      kill_reg,
  input  logic [REG_IDX_W-1:0]      query_reg,
  output logic                      query_hit,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_IDX_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0]     kill_q;
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W-1:0]     tail_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = '{reg_idx: reg_q[head_ptr], data: data_q[head_ptr], kill: kill_q[head_ptr]};

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i] && reg_q[i] == query_reg) query_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      kill_q   <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && valid_q[i] && reg_q[i] == kill_reg) kill_q[i] <= 1'b1;
      end
      // Push and pop never share a slot: pop needs !empty, push needs !full.
      if (push) begin
        reg_q[tail_ptr]   <= push_reg;
        data_q[tail_ptr]  <= push_data;
        kill_q[tail_ptr]  <= kill_en && (kill_reg == push_reg);
        valid_q[tail_ptr] <= 1'b1;
        tail_ptr          <= tail_ptr + 1'b1;
      end
      if (pop) begin
        valid_q[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// rtl/reg_writeback_arbiter.sv - merges ALU and load results into the single register-file write port
// Purpose: arbiter, starvation wait counter and registered write port. Optional macro WB_R0_DISCARD_EN
//   suppresses writes to r0 and r0 hazard hits.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  reg_writeback_arbiter_if.master: ALU stream + stall, load stream + ready,
//        hazard query, regWrite/writeReg/writeData, pending count
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  reg_writeback_arbiter_if.master   bus
);

  wb_entry_t            head;
  logic [$clog2(DEPTH):0] count;
  logic                 q_full;
  logic                 q_empty;
  logic                 q_hit;
  logic                 stall_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WAIT_W-1:0]    wait_next;
  logic                 alu_go;
  logic                 push;
  logic                 pop;
  logic                 commit_en;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] commit_reg;
  logic [DATA_W-1:0]    commit_data;

  // During the stall slot the head owns the port even if alu_valid is (illegally) high.
  assign alu_go = bus.alu_valid && !stall_q;
  assign push   = bus.mem_valid && !q_full;
  assign pop    = !q_empty && !alu_go;

  wb_load_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_reg  (bus.mem_reg),
    .push_data (bus.mem_data),
    .pop       (pop),
    .kill_en   (alu_go),
    .kill_reg  (bus.alu_reg),
    .query_reg (bus.query_reg),
    .query_hit (q_hit),
    .head      (head),
    .count     (count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    wait_next = '0;
    if (!pop && !q_empty) wait_next = wait_cnt + 1'b1;
  end

  always_comb begin
    commit_en   = 1'b0;
    commit_reg  = head.reg_idx;
    commit_data = head.data;
    if (alu_go) begin
      commit_en   = 1'b1;
      commit_reg  = bus.alu_reg;
      commit_data = bus.alu_data;
    end else if (pop && !head.kill) begin
      commit_en = 1'b1;
    end
  end

`ifdef WB_R0_DISCARD_EN
  assign wr_en         = commit_en && (commit_reg != '0);
  assign bus.query_hit = q_hit && (bus.query_reg != '0);
`else
  assign wr_en         = commit_en;
  assign bus.query_hit = q_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      stall_q       <= 1'b0;
      bus.regWrite  <= 1'b0;
      bus.writeReg  <= '0;
      bus.writeData <= '0;
    end else begin
      wait_cnt     <= wait_next;
      // Reaching the limit stalls the ALU for one cycle; the forced pop then clears the counter.
      stall_q      <= (wait_next == WAIT_W'(MAX_WAIT));
      bus.regWrite <= wr_en;
      if (wr_en) begin
        bus.writeReg  <= commit_reg;
        bus.writeData <= commit_data;
      end
    end
  end

  assign bus.alu_stall = stall_q;
  assign bus.mem_ready = !q_full;
  assign bus.pending   = count;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb/tb_reg_writeback_arbiter.sv - directed self-checking bench with write scoreboard
module tb_reg_writeback_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  wr_t  sb[$];

  always #5 clk = ~clk;

  reg_writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_reg   = r;
    bus.alu_data  = d;
  endtask

  task automatic mem(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.mem_valid = v;
    bus.mem_reg   = r;
    bus.mem_data  = d;
  endtask

  // Every regWrite must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.regWrite === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'd0, bus.writeReg}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_reg", {27'd0, bus.writeReg}, {27'd0, e.r});
        check("sb_data", bus.writeData, e.d);
      end
    end
  end

  int stall_pulses;
  int stall_cycle;

  initial begin
    alu(1'b0, 5'd0, 32'd0);
    mem(1'b0, 5'd0, 32'd0);
    bus.query_reg = 5'd0;

    // Reset state
    tick();
    tick();
    check("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("rst_writeReg", {27'd0, bus.writeReg}, 32'd0);
    check("rst_writeData", bus.writeData, 32'd0);
    check("rst_stall", {31'd0, bus.alu_stall}, 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_ready", {31'd0, bus.mem_ready}, 32'd1);
    rst = 1'b0;

    // Three loads held in the queue by ALU traffic, then reset discards them
    for (int i = 0; i < 3; i++) begin
      alu(1'b1, 5'd10, 32'h100 + 32'(i));
      mem(1'b1, 5'(i + 1), 32'h200 + 32'(i));
      sb.push_back('{r: 5'd10, d: 32'h100 + 32'(i)});
      tick();
    end
    mem(1'b0, 5'd0, 32'd0);
    check("fill3_pending", 32'(bus.pending), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu(1'b0, 5'd0, 32'd0);
    bus.query_reg = 5'd1;
    #1;
    check("rst3_pending", 32'(bus.pending), 32'd0);
    check("rst3_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("rst3_ready", {31'd0, bus.mem_ready}, 32'd1);
    check("rst3_query", {31'd0, bus.query_hit}, 32'd0);

    // Single load, two cycles to the write port
    mem(1'b1, 5'd5, 32'hDEAD_BEEF);
    sb.push_back('{r: 5'd5, d: 32'hDEAD_BEEF});
    tick();
    mem(1'b0, 5'd0, 32'd0);
    bus.query_reg = 5'd5;
    #1;
    check("ld_enq_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("ld_enq_pending", 32'(bus.pending), 32'd1);
    check("ld_enq_query", {31'd0, bus.query_hit}, 32'd1);
    tick();
    check("ld_regWrite", {31'd0, bus.regWrite}, 32'd1);
    check("ld_writeReg", {27'd0, bus.writeReg}, 32'd5);
    check("ld_writeData", bus.writeData, 32'hDEAD_BEEF);
    check("ld_pending", 32'(bus.pending), 32'd0);

    // WAW: queued load to r7 superseded by a later ALU write to r7
    alu(1'b1, 5'd9, 32'h99);
    mem(1'b1, 5'd7, 32'h1);
    sb.push_back('{r: 5'd9, d: 32'h99});
    tick();
    mem(1'b0, 5'd0, 32'd0);
    alu(1'b1, 5'd7, 32'h2);
    sb.push_back('{r: 5'd7, d: 32'h2});
    tick();
    alu(1'b0, 5'd0, 32'd0);
    bus.query_reg = 5'd7;
    #1;
    check("waw_query", {31'd0, bus.query_hit}, 32'd0);
    check("waw_pending", 32'(bus.pending), 32'd1);
    tick();
    check("waw_pop_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("waw_pop_pending", 32'(bus.pending), 32'd0);
    check("waw_hold_reg", {27'd0, bus.writeReg}, 32'd7);
    check("waw_hold_data", bus.writeData, 32'h2);

    // Same-cycle load and ALU op to r8: the ALU op is newer
    alu(1'b1, 5'd8, 32'h88);
    mem(1'b1, 5'd8, 32'h77);
    sb.push_back('{r: 5'd8, d: 32'h88});
    tick();
    alu(1'b0, 5'd0, 32'd0);
    mem(1'b0, 5'd0, 32'd0);
    tick();
    check("same_pop_regWrite", {31'd0, bus.regWrite}, 32'd0);
    check("same_pop_pending", 32'(bus.pending), 32'd0);

    // Starvation: continuous ALU traffic with one queued load
    alu(1'b1, 5'd13, 32'h300);
    mem(1'b1, 5'd12, 32'h1234);
    sb.push_back('{r: 5'd13, d: 32'h300});
    tick();
    mem(1'b0, 5'd0, 32'd0);
    stall_pulses = 0;
    stall_cycle  = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.alu_stall === 1'b1) begin
        stall_pulses++;
        stall_cycle = c;
        alu(1'b0, 5'd0, 32'd0);
        sb.push_back('{r: 5'd12, d: 32'h1234});
      end else begin
        alu(1'b1, 5'd13, 32'h400 + 32'(c));
        sb.push_back('{r: 5'd13, d: 32'h400 + 32'(c)});
      end
      tick();
    end
    alu(1'b0, 5'd0, 32'd0);
    check("stall_pulses", 32'(stall_pulses), 32'd1);
    check("stall_cycle", 32'(stall_cycle), 32'(MAX_WAIT));
    check("stall_pending", 32'(bus.pending), 32'd0);
    tick();

    // Full queue: four loads held by ALU traffic, fifth refused
    for (int i = 0; i < DEPTH; i++) begin
      alu(1'b1, 5'd30, 32'h500 + 32'(i));
      mem(1'b1, 5'(20 + i), 32'h600 + 32'(i));
      sb.push_back('{r: 5'd30, d: 32'h500 + 32'(i)});
      tick();
    end
    check("full_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("full_pending", 32'(bus.pending), 32'(DEPTH));
    alu(1'b1, 5'd30, 32'h5FF);
    mem(1'b1, 5'd24, 32'h6FF);
    sb.push_back('{r: 5'd30, d: 32'h5FF});
    tick();
    mem(1'b0, 5'd0, 32'd0);
    alu(1'b0, 5'd0, 32'd0);
    check("full_5th_pending", 32'(bus.pending), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      bus.query_reg = 5'(20 + i);
      #1;
      check("full_query", {31'd0, bus.query_hit}, 32'd1);
    end
    bus.query_reg = 5'd24;
    #1;
    check("full_query_5th", {31'd0, bus.query_hit}, 32'd0);
    for (int i = 0; i < DEPTH; i++) sb.push_back('{r: 5'(20 + i), d: 32'h600 + 32'(i)});
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) tick();
    check("drain_pending", 32'(bus.pending), 32'd0);
    check("drain_ready", {31'd0, bus.mem_ready}, 32'd1);

    // ALU write to r0
    alu(1'b1, 5'd0, 32'h0000_FFFF);
`ifndef WB_R0_DISCARD_EN
    sb.push_back('{r: 5'd0, d: 32'h0000_FFFF});
`endif
    tick();
    alu(1'b0, 5'd0, 32'd0);
`ifdef WB_R0_DISCARD_EN
    check("r0_regWrite", {31'd0, bus.regWrite}, 32'd0);
`else
    check("r0_regWrite", {31'd0, bus.regWrite}, 32'd1);
`endif
    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side master for the processor's 32x32 register file; owns its single write port (regWrite, write index, writeData).
- Merges two result streams into one register-file write per cycle:
  - single-cycle ALU/branch-link results;
  - variable-latency load results from data memory.
- Load results are buffered in a small queue. Write-after-write ordering is kept so a newer ALU write is never overwritten by an older load.
- Provides a pending-write lookup so decode can detect load-use hazards.

Parameters:
- DEPTH, 4, load-result queue entries (power of two, 2..16)
- MAX_WAIT, 8, cycles a queued load may be blocked by ALU traffic before the ALU is stalled (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU stage must hold; alu_valid must be 0 while high
- mem_valid  in  1  load result offered
- mem_ready  out  1  queue can accept (!full)
- mem_reg  in  5  load destination register
- mem_data  in  32  load data
- query_reg  in  5  decode source register to check
- query_hit  out  1  query_reg has a live queued load write (combinational)
- regWrite  out  1  register-file write enable (registered)
- writeReg  out  5  register-file write index (registered)
- writeData  out  32  register-file write data (registered)
- pending  out  $clog2(DEPTH)+1  live-or-killed entries in queue

Behaviour:
- Reset:
  - All outputs 0 on the first clk edge with rst=1; mem_ready=1 in the following cycle.
  - Queue pointers, kill bits and the wait counter are cleared. Any queued loads are discarded.
  - rst dominates all same-cycle inputs.
- Load acceptance: a load enters the queue when mem_valid && mem_ready. The entry is the tail, stored with kill=0.
- Arbitration, evaluated each cycle; the commit is registered, so the write appears 1 cycle later:
  - alu_valid=1: commit the ALU result.
  - Else, if the queue is non-empty: pop the head and commit it if kill=0. If kill=1, discard it, hold regWrite=0, and still pop.
  - Else: regWrite=0.
- WAW kill:
  - An ALU commit sets kill on every queue entry whose reg equals alu_reg, including an entry being enqueued in the same cycle.
  - A load and an ALU op targeting the same reg in the same cycle count the ALU op as newer.
- Starvation:
  - wait_cnt increments each cycle the queue is non-empty and the head is not popped; it clears on any pop.
  - When wait_cnt == MAX_WAIT, alu_stall is asserted (registered) for exactly one cycle. In that cycle the head pops.
- Full: mem_ready=0 when count==DEPTH. A simultaneous pop and push when full is not allowed, because ready is based on registered count.
- Empty: with no alu_valid, regWrite=0 and the outputs hold their last index/data.
- Pointer wrap-around is modulo DEPTH; count is tracked separately.
- query_hit is 1 iff a queue entry has kill=0 and reg==query_reg.
- Register 0 is treated like any other register unless the feature below is enabled.

Optional Feature:
- Macro: WB_R0_DISCARD_EN.
- When defined:
  - Any commit with destination 0 drives regWrite=0.
  - query_hit is never asserted for query_reg=0.
  - Loads to r0 are still queued and popped, to keep ordering.
- When undefined: r0 is written normally.

Decomposition:
- Shared package: REG_IDX_W=5, DATA_W=32, wb_entry_t {reg, data, kill}.
- One natural sub-module, wb_load_queue: circular buffer with push/pop, kill-by-match broadcast, and match lookup.
- The top level holds the arbiter, the wait counter and the output registers.

Test Plan:
- Reset with 3 loads queued -> next cycle pending=0, regWrite=0, mem_ready=1.
- Load r5=0xDEAD_BEEF, no ALU traffic -> regWrite=1, writeReg=5, writeData=0xDEADBEEF two cycles after acceptance (enqueue, then commit register).
- Load r7=0x1 queued, then ALU r7=0x2 while the load is still queued -> only r7=0x2 written; the load pops with regWrite=0.
- ALU valid every cycle with 1 load queued, MAX_WAIT=8 -> alu_stall pulses once after 8 blocked cycles; the load is written in that slot.
- Push 4 loads with no pops, DEPTH=4 -> mem_ready=0 and pending=4. A 5th mem_valid is not accepted. query_hit=1 for each queued reg.
- With WB_R0_DISCARD_EN, ALU r0=0xFFFF -> regWrite stays 0.
